// File: rtl/memory_arbiter_if.sv
// Reset interface shared across the codebase.
//   rst : synchronous, active-high reset
// The sink modport is for blocks that consume the reset; source is for the reset generator.
interface reset_if;
    logic rst;

    modport sink   (input  rst);
    modport source (output rst);
endinterface

// File: rtl/memory_arbiter.sv
// Two-requester, one-server arbiter between the instruction-cache and data-cache miss ports and a
// single backing-memory port. One memory transaction is outstanding at a time. Ties are broken
// round-robin. Each grant is latched, forwarded to memory, and the response is returned to the
// originating port as a one-cycle fulfilled pulse.
//
// Ports:
//   clk_i                  system clock, all state on the rising edge
//   rst_if                 reset interface (synchronous, active-high)
//   reqN_valid_i           port N request pending, held until reqN_fulfilled_o
//   reqN_op_i              0 = load, 1 = store
//   reqN_addr_i            word address
//   reqN_wdata_i           store data
//   reqN_rdata_o           load data, valid with reqN_fulfilled_o, held until the next pulse
//   reqN_fulfilled_o       one-cycle completion pulse
//   mem_valid_o            request to backing memory
//   mem_op_o               0 = load, 1 = store
//   mem_addr_o/mem_wdata_o latched address / store data
//   mem_rdata_i            memory load data, valid with mem_fulfilled_i
//   mem_fulfilled_i        one-cycle completion from memory
//   ro_violation_o         sticky flag: port 0 issued a store while it is read-only
module memory_arbiter #(
    parameter int unsigned XLEN            = 32,
    parameter bit          PORT0_READ_ONLY = 1'b1
) (
    input  logic            clk_i,
    reset_if.sink           rst_if,

    input  logic            req0_valid_i,
    input  logic            req0_op_i,
    input  logic [XLEN-1:0] req0_addr_i,
    input  logic [XLEN-1:0] req0_wdata_i,
    output logic [XLEN-1:0] req0_rdata_o,
    output logic            req0_fulfilled_o,

    input  logic            req1_valid_i,
    input  logic            req1_op_i,
    input  logic [XLEN-1:0] req1_addr_i,
    input  logic [XLEN-1:0] req1_wdata_i,
    output logic [XLEN-1:0] req1_rdata_o,
    output logic            req1_fulfilled_o,

    output logic            mem_valid_o,
    output logic            mem_op_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic [XLEN-1:0] mem_rdata_i,
    input  logic            mem_fulfilled_i,

    output logic            ro_violation_o
);

    typedef enum logic [1:0] {StIdle, StMem, StResp} state_e;

    state_e          state_q;
    logic            last_grant_q;
    logic            gnt_q;
    logic            mem_valid_q;
    logic            mem_op_q;
    logic [XLEN-1:0] mem_addr_q;
    logic [XLEN-1:0] mem_wdata_q;
    logic [XLEN-1:0] req0_rdata_q;
    logic [XLEN-1:0] req1_rdata_q;
    logic            req0_fulfilled_q;
    logic            req1_fulfilled_q;
    logic            ro_violation_q;

    // Arbitration decision, only consumed in StIdle.
    logic            any_req;
    logic            sel;
    logic            sel_op;
    logic [XLEN-1:0] sel_addr;
    logic [XLEN-1:0] sel_wdata;
    logic            ro_reject;

    always_comb begin
        any_req = req0_valid_i | req1_valid_i;
        sel     = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            // Contended: the port that did not win last time goes next.
            sel = ~last_grant_q;
        end else if (req1_valid_i) begin
            sel = 1'b1;
        end
        sel_op    = sel ? req1_op_i    : req0_op_i;
        sel_addr  = sel ? req1_addr_i  : req0_addr_i;
        sel_wdata = sel ? req1_wdata_i : req0_wdata_i;
        ro_reject = PORT0_READ_ONLY && !sel && req0_op_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_if.rst) begin
            state_q          <= StIdle;
            last_grant_q     <= 1'b1;  // port 0 wins the first tie
            gnt_q            <= 1'b0;
            mem_valid_q      <= 1'b0;
            mem_op_q         <= 1'b0;
            mem_addr_q       <= '0;
            mem_wdata_q      <= '0;
            req0_rdata_q     <= '0;
            req1_rdata_q     <= '0;
            req0_fulfilled_q <= 1'b0;
            req1_fulfilled_q <= 1'b0;
            ro_violation_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        last_grant_q <= sel;
                        gnt_q        <= sel;
                        if (ro_reject) begin
                            // Rejected store completes locally; rdata is left untouched.
                            ro_violation_q   <= 1'b1;
                            req0_fulfilled_q <= 1'b1;
                            state_q          <= StResp;
                        end else begin
                            mem_valid_q <= 1'b1;
                            mem_op_q    <= sel_op;
                            mem_addr_q  <= sel_addr;
                            mem_wdata_q <= sel_wdata;
                            state_q     <= StMem;
                        end
                    end
                end
                StMem: begin
                    // Requester inputs are ignored here; the latched mem_* copy is authoritative.
                    if (mem_fulfilled_i) begin
                        if (gnt_q) begin
                            req1_rdata_q     <= mem_rdata_i;
                            req1_fulfilled_q <= 1'b1;
                        end else begin
                            req0_rdata_q     <= mem_rdata_i;
                            req0_fulfilled_q <= 1'b1;
                        end
                        mem_valid_q <= 1'b0;
                        state_q     <= StResp;
                    end
                end
                StResp: begin
                    req0_fulfilled_q <= 1'b0;
                    req1_fulfilled_q <= 1'b0;
                    state_q          <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign mem_valid_o      = mem_valid_q;
    assign mem_op_o         = mem_op_q;
    assign mem_addr_o       = mem_addr_q;
    assign mem_wdata_o      = mem_wdata_q;
    assign req0_rdata_o     = req0_rdata_q;
    assign req1_rdata_o     = req1_rdata_q;
    assign req0_fulfilled_o = req0_fulfilled_q;
    assign req1_fulfilled_o = req1_fulfilled_q;
    assign ro_violation_o   = ro_violation_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: queue-driven requesters, a latency-programmable memory
// model, and scoreboards for expected memory requests and expected port responses.
module tb_memory_arbiter;

    typedef struct {
        int          port;
        logic        op;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        int          port;
        logic [31:0] rdata;
    } resp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    reset_if rst_bus ();

    logic        req0_valid_i, req0_op_i, req0_fulfilled_o;
    logic [31:0] req0_addr_i, req0_wdata_i, req0_rdata_o;
    logic        req1_valid_i, req1_op_i, req1_fulfilled_o;
    logic [31:0] req1_addr_i, req1_wdata_i, req1_rdata_o;
    logic        mem_valid_o, mem_op_o, mem_fulfilled_i, ro_violation_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    memory_arbiter #(
        .XLEN            (32),
        .PORT0_READ_ONLY (1'b1)
    ) dut (
        .clk_i            (clk),
        .rst_if           (rst_bus),
        .req0_valid_i     (req0_valid_i),
        .req0_op_i        (req0_op_i),
        .req0_addr_i      (req0_addr_i),
        .req0_wdata_i     (req0_wdata_i),
        .req0_rdata_o     (req0_rdata_o),
        .req0_fulfilled_o (req0_fulfilled_o),
        .req1_valid_i     (req1_valid_i),
        .req1_op_i        (req1_op_i),
        .req1_addr_i      (req1_addr_i),
        .req1_wdata_i     (req1_wdata_i),
        .req1_rdata_o     (req1_rdata_o),
        .req1_fulfilled_o (req1_fulfilled_o),
        .mem_valid_o      (mem_valid_o),
        .mem_op_o         (mem_op_o),
        .mem_addr_o       (mem_addr_o),
        .mem_wdata_o      (mem_wdata_o),
        .mem_rdata_i      (mem_rdata_i),
        .mem_fulfilled_i  (mem_fulfilled_i),
        .ro_violation_o   (ro_violation_o)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    req_t  q0[$], q1[$], exp_mem[$];
    resp_t exp_resp[$];
    int    ful_cyc1[$];
    int    ful_cnt0 = 0, ful_cnt1 = 0;
    logic [31:0] last_rd0 = '0, last_rd1 = '0;
    int    start0 = 0;
    int    mem_lat = 0;
    bit    stray_req = 1'b0;
    bit    perturb1 = 1'b0;
    req_t  mem_cur;
    int    mem_cnt = 0;
    bit    mem_busy = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] addr);
        if (addr == 32'h100) return 32'hDEADBEEF;
        return addr * 32'd7 + 32'h1357_0000;
    endfunction

    task automatic sync();
        @(posedge clk);
        #3;
    endtask

    task automatic push_req(input int port, input logic op, input logic [31:0] addr,
                            input logic [31:0] wdata, input bit to_mem);
        req_t r;
        r.port = port; r.op = op; r.addr = addr; r.wdata = wdata;
        if (port == 0) q0.push_back(r); else q1.push_back(r);
        if (to_mem) exp_mem.push_back(r);
    endtask

    task automatic wait_mem(input string tag);
        int n = 0;
        while (n < 50 && !mem_valid_o) begin
            sync();
            n++;
        end
        check_eq({tag, "_mem_seen"}, 32'(n < 50), 1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (n < 300 && !(q0.size() == 0 && q1.size() == 0 && !req0_valid_i && !req1_valid_i &&
                            exp_mem.size() == 0 && exp_resp.size() == 0 && !mem_valid_o)) begin
            sync();
            n++;
        end
        check_eq({tag, "_done"}, 32'(n < 300), 1);
        sync();
    endtask

    // Requester 0: presents queued requests, drops valid after its fulfilled pulse.
    initial begin
        req_t r;
        req0_valid_i = 1'b0; req0_op_i = 1'b0; req0_addr_i = '0; req0_wdata_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_bus.rst) begin
                req0_valid_i = 1'b0;
            end else begin
                if (req0_valid_i && req0_fulfilled_o) req0_valid_i = 1'b0;
                if (!req0_valid_i && q0.size() > 0) begin
                    r = q0.pop_front();
                    req0_op_i = r.op; req0_addr_i = r.addr; req0_wdata_i = r.wdata;
                    req0_valid_i = 1'b1;
                    start0 = cyc;
                end
            end
        end
    end

    // Requester 1: same, plus optional scrambling of addr/wdata while its request is in flight.
    initial begin
        req_t r;
        req1_valid_i = 1'b0; req1_op_i = 1'b0; req1_addr_i = '0; req1_wdata_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_bus.rst) begin
                req1_valid_i = 1'b0;
            end else begin
                if (req1_valid_i && req1_fulfilled_o) req1_valid_i = 1'b0;
                if (req1_valid_i && perturb1) begin
                    req1_addr_i  = ~req1_addr_i;
                    req1_wdata_i = req1_wdata_i + 32'd1;
                end
                if (!req1_valid_i && q1.size() > 0) begin
                    r = q1.pop_front();
                    req1_op_i = r.op; req1_addr_i = r.addr; req1_wdata_i = r.wdata;
                    req1_valid_i = 1'b1;
                end
            end
        end
    end

    // Memory model: checks each new request against the expected order, checks it stays stable,
    // replies after mem_lat extra cycles, and can inject a stray fulfilled on request.
    initial begin
        mem_fulfilled_i = 1'b0;
        mem_rdata_i     = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_fulfilled_i = 1'b0;
            if (stray_req) begin
                mem_fulfilled_i = 1'b1;
                mem_rdata_i     = 32'hBAD0BAD0;
                stray_req       = 1'b0;
            end else if (mem_valid_o === 1'b1) begin
                if (!mem_busy) begin
                    mem_busy = 1'b1;
                    mem_cnt  = 0;
                    check_eq("mem_req_expected", 32'(exp_mem.size() > 0), 1);
                    if (exp_mem.size() > 0) begin
                        resp_t e;
                        mem_cur = exp_mem.pop_front();
                        check_eq("mem_op", 32'(mem_op_o), 32'(mem_cur.op));
                        check_eq("mem_addr", mem_addr_o, mem_cur.addr);
                        if (mem_cur.op) check_eq("mem_wdata", mem_wdata_o, mem_cur.wdata);
                        e.port  = mem_cur.port;
                        e.rdata = mem_data(mem_cur.addr);
                        exp_resp.push_back(e);
                    end else begin
                        mem_cur.op = mem_op_o; mem_cur.addr = mem_addr_o;
                        mem_cur.wdata = mem_wdata_o; mem_cur.port = -1;
                    end
                end else begin
                    check_eq("mem_op_hold", 32'(mem_op_o), 32'(mem_cur.op));
                    check_eq("mem_addr_hold", mem_addr_o, mem_cur.addr);
                    check_eq("mem_wdata_hold", mem_wdata_o, mem_wdata_o === mem_cur.wdata ?
                             mem_cur.wdata : (mem_cur.op ? mem_cur.wdata : mem_wdata_o));
                end
                if (mem_cnt == mem_lat) begin
                    mem_fulfilled_i = 1'b1;
                    mem_rdata_i     = mem_data(mem_addr_o);
                end
                mem_cnt++;
            end else begin
                mem_busy = 1'b0;
            end
        end
    end

    // Response monitor: every fulfilled pulse must match the head of the response scoreboard.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (req0_fulfilled_o === 1'b1 || req1_fulfilled_o === 1'b1) begin : mon
                int    p;
                resp_t e;
                p = (req1_fulfilled_o === 1'b1) ? 1 : 0;
                check_eq("ful_onehot", 32'(req0_fulfilled_o & req1_fulfilled_o), 0);
                check_eq("resp_expected", 32'(exp_resp.size() > 0), 1);
                if (exp_resp.size() > 0) begin
                    e = exp_resp.pop_front();
                    check_eq("resp_port", p, e.port);
                    check_eq("resp_rdata", (p == 1) ? req1_rdata_o : req0_rdata_o, e.rdata);
                    if (p == 1) last_rd1 = e.rdata; else last_rd0 = e.rdata;
                end
                if (p == 1) begin
                    ful_cnt1++;
                    ful_cyc1.push_back(cyc);
                end else begin
                    ful_cnt0++;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_bus.rst = 1'b1;
        repeat (2) sync();
        exp_resp.delete();
        rst_bus.rst = 1'b0;
        sync();
    endtask

    initial begin
        logic [31:0] keep0, keep1;
        int c0;
        rst_bus.rst = 1'b1;
        repeat (2) sync();
        check_eq("rst_mem_valid", 32'(mem_valid_o), 0);
        check_eq("rst_mem_op", 32'(mem_op_o), 0);
        check_eq("rst_mem_addr", mem_addr_o, 0);
        check_eq("rst_mem_wdata", mem_wdata_o, 0);
        check_eq("rst_rdata0", req0_rdata_o, 0);
        check_eq("rst_rdata1", req1_rdata_o, 0);
        check_eq("rst_ful0", 32'(req0_fulfilled_o), 0);
        check_eq("rst_ful1", 32'(req1_fulfilled_o), 0);
        check_eq("rst_ro", 32'(ro_violation_o), 0);
        rst_bus.rst = 1'b0;
        sync();

        // Lone port-0 load, memory answers after two wait cycles.
        mem_lat = 2;
        push_req(0, 1'b0, 32'h100, 32'h0, 1'b1);
        wait_mem("t1");
        check_eq("t1_req_latency", 32'(cyc - start0), 1);
        check_eq("t1_addr", mem_addr_o, 32'h100);
        wait_done("t1");
        check_eq("t1_rdata0", req0_rdata_o, 32'hDEADBEEF);
        check_eq("t1_ful0_cnt", ful_cnt0, 1);
        check_eq("t1_ful1_cnt", ful_cnt1, 0);

        // Contention from reset: strict alternation starting with port 0.
        do_reset();
        mem_lat = 0;
        push_req(0, 1'b0, 32'h40, 32'h0, 1'b0);
        push_req(1, 1'b1, 32'h80, 32'h12345678, 1'b0);
        push_req(0, 1'b0, 32'h44, 32'h0, 1'b0);
        push_req(1, 1'b0, 32'h84, 32'h0, 1'b0);
        push_req(0, 1'b0, 32'h48, 32'h0, 1'b0);
        push_req(1, 1'b1, 32'h88, 32'hCAFEF00D, 1'b0);
        foreach (q0[i]) begin
            exp_mem.push_back(q0[i]);
            exp_mem.push_back(q1[i]);
        end
        wait_done("t2");
        check_eq("t2_ful0_cnt", ful_cnt0, 4);
        check_eq("t2_ful1_cnt", ful_cnt1, 3);

        // Persistent single requester: back-to-back grants, 3 cycles each.
        ful_cyc1.delete();
        push_req(1, 1'b0, 32'h200, 32'h0, 1'b1);
        push_req(1, 1'b0, 32'h204, 32'h0, 1'b1);
        push_req(1, 1'b0, 32'h208, 32'h0, 1'b1);
        wait_done("t3");
        check_eq("t3_count", ful_cyc1.size(), 3);
        if (ful_cyc1.size() == 3) begin
            check_eq("t3_turn_a", 32'(ful_cyc1[1] - ful_cyc1[0]), 3);
            check_eq("t3_turn_b", 32'(ful_cyc1[2] - ful_cyc1[1]), 3);
        end
        check_eq("t3_rdata1", req1_rdata_o, mem_data(32'h208));

        // Port-0 store is rejected locally: no memory traffic, pulse, sticky flag.
        keep0 = req0_rdata_o;
        c0 = ful_cnt0;
        begin
            resp_t e;
            e.port = 0; e.rdata = keep0;
            exp_resp.push_back(e);
        end
        push_req(0, 1'b1, 32'h300, 32'h55, 1'b0);
        wait_done("t4");
        check_eq("t4_ro", 32'(ro_violation_o), 1);
        check_eq("t4_rdata0_kept", req0_rdata_o, keep0);
        check_eq("t4_ful0_cnt", ful_cnt0, c0 + 1);
        // The rejected store counted as port 0's turn, so port 1 wins the next tie.
        push_req(0, 1'b0, 32'h400, 32'h0, 1'b0);
        push_req(1, 1'b0, 32'h500, 32'h0, 1'b0);
        exp_mem.push_back(q1[0]);
        exp_mem.push_back(q0[0]);
        wait_done("t4b");
        check_eq("t4_ro_sticky", 32'(ro_violation_o), 1);

        // Requester scribbles on addr/wdata mid-transaction; then a stray mem_fulfilled in IDLE.
        mem_lat = 4;
        push_req(1, 1'b1, 32'h600, 32'h77, 1'b1);
        wait_mem("t6");
        perturb1 = 1'b1;
        sync();
        check_eq("t6_addr_latched", mem_addr_o, 32'h600);
        check_eq("t6_wdata_latched", mem_wdata_o, 32'h77);
        wait_done("t6");
        perturb1 = 1'b0;
        keep0 = req0_rdata_o;
        keep1 = req1_rdata_o;
        c0 = ful_cnt0 + ful_cnt1;
        stray_req = 1'b1;
        repeat (3) sync();
        check_eq("t6_stray_mem_valid", 32'(mem_valid_o), 0);
        check_eq("t6_stray_rdata0", req0_rdata_o, keep0);
        check_eq("t6_stray_rdata1", req1_rdata_o, keep1);
        check_eq("t6_stray_ful", ful_cnt0 + ful_cnt1, c0);
        push_req(0, 1'b0, 32'h700, 32'h0, 1'b1);
        wait_done("t6b");
        check_eq("t6b_rdata0", req0_rdata_o, mem_data(32'h700));

        // Reset while waiting on memory: transaction abandoned, flag cleared, port recovers.
        mem_lat = 5;
        c0 = ful_cnt0 + ful_cnt1;
        push_req(0, 1'b0, 32'h800, 32'h0, 1'b1);
        wait_mem("t5");
        rst_bus.rst = 1'b1;
        sync();
        check_eq("t5_mem_valid", 32'(mem_valid_o), 0);
        check_eq("t5_ful0", 32'(req0_fulfilled_o), 0);
        check_eq("t5_ful1", 32'(req1_fulfilled_o), 0);
        check_eq("t5_ro_cleared", 32'(ro_violation_o), 0);
        exp_resp.delete();
        sync();
        rst_bus.rst = 1'b0;
        sync();
        stray_req = 1'b1;
        repeat (3) sync();
        check_eq("t5_stray_rdata0", req0_rdata_o, 0);
        check_eq("t5_stray_mem_valid", 32'(mem_valid_o), 0);
        check_eq("t5_no_pulse", ful_cnt0 + ful_cnt1, c0);
        mem_lat = 1;
        push_req(1, 1'b0, 32'h900, 32'h0, 1'b1);
        wait_done("t5b");
        check_eq("t5b_rdata1", req1_rdata_o, mem_data(32'h900));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
